// File: rtl/rv64g_l2_probe_ctrl.sv
// Per-request L2 coherence controller: reads one directory entry, probes the L1s
// that must give up or downgrade the line, gathers acks, then writes the entry back.
module rv64g_l2_probe_ctrl #(
  parameter  int SETS  = 256,
  parameter  int WAYS  = 16,
  parameter  int CORES = 4,
  localparam int SW    = $clog2(SETS),
  localparam int WW    = $clog2(WAYS),
  localparam int OID   = $clog2(CORES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [SW-1:0]         req_set_i,
  input  logic [WW-1:0]         req_way_i,
  input  logic [OID-1:0]        req_core_i,
  input  logic                  req_excl_i,
  output logic [SW-1:0]         dir_rd_set_o,
  input  logic [WAYS-1:0]       dir_rd_valid_i,
  input  logic [WAYS*CORES-1:0] dir_rd_sharers_i,
  input  logic [WAYS-1:0]       dir_rd_owner_valid_i,
  input  logic [WAYS*OID-1:0]   dir_rd_owner_id_i,
  input  logic [WAYS-1:0]       dir_rd_dirty_i,
  output logic                  dir_we_o,
  output logic [SW-1:0]         dir_wr_set_o,
  output logic [WW-1:0]         dir_wr_way_o,
  output logic                  dir_wr_valid_o,
  output logic [CORES-1:0]      dir_wr_sharers_o,
  output logic                  dir_wr_owner_valid_o,
  output logic [OID-1:0]        dir_wr_owner_id_o,
  output logic                  dir_wr_dirty_o,
  output logic                  probe_valid_o,
  input  logic                  probe_ready_i,
  output logic [OID-1:0]        probe_core_o,
  output logic                  probe_toN_o,
  input  logic                  ack_valid_i,
  input  logic [OID-1:0]        ack_core_i,
  input  logic                  ack_dirty_i,
  output logic                  done_o,
  output logic                  done_dirty_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {IDLE, LOOKUP, PROBE, UPDATE} state_t;

  localparam logic [CORES-1:0] ONE = CORES'(1);

  state_t state_q, state_d;

  logic [SW-1:0]    set_q;
  logic [WW-1:0]    way_q;
  logic [OID-1:0]   core_q;
  logic             excl_q;
  logic             e_valid_q, e_owner_valid_q, e_dirty_q;
  logic [CORES-1:0] e_sharers_q;
  logic [OID-1:0]   e_owner_id_q;
  logic [CORES-1:0] p_q, m_q;
  logic             d_q, ton_q;

  logic             sel_valid, sel_owner_valid, sel_dirty;
  logic [CORES-1:0] sel_sharers, sel_oh, e_oh, rq, p_init, p_next, m_next;
  logic [OID-1:0]   sel_owner_id, low_idx;
  logic             probe_fire, ack_hit, d_next;

  assign sel_valid       = dir_rd_valid_i[way_q];
  assign sel_owner_valid = dir_rd_owner_valid_i[way_q];
  assign sel_dirty       = dir_rd_dirty_i[way_q];
  assign sel_sharers     = dir_rd_sharers_i[way_q*CORES +: CORES];
  assign sel_owner_id    = dir_rd_owner_id_i[way_q*OID +: OID];

  assign rq     = ONE << core_q;
  assign sel_oh = ONE << sel_owner_id;
  assign e_oh   = ONE << e_owner_id_q;

  assign dir_rd_set_o = set_q;

  always_comb begin
    p_init = '0;
    if (sel_valid) begin
      if (excl_q) begin
        p_init = (sel_owner_valid ? sel_oh : sel_sharers) & ~rq;
      end else if (sel_owner_valid && (sel_owner_id != core_q)) begin
        p_init = sel_oh;
      end
    end
  end

  // Probes go out lowest core first; the pending-probe mask only shrinks on a handshake
  always_comb begin
    low_idx = '0;
    for (int i = CORES - 1; i >= 0; i--) begin
      if (p_q[i]) low_idx = OID'(i);
    end
  end

  assign probe_fire = (state_q == PROBE) && (p_q != '0) && probe_ready_i;
  assign ack_hit    = (state_q == PROBE) && ack_valid_i && m_q[ack_core_i];
  assign p_next     = p_q & ~(probe_fire ? (ONE << low_idx) : '0);
  assign m_next     = m_q & ~(ack_hit ? (ONE << ack_core_i) : '0);
  assign d_next     = d_q | (ack_hit & ack_dirty_i);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i) state_d = LOOKUP;
      LOOKUP:  state_d = (p_init != '0) ? PROBE : UPDATE;
      PROBE:   if ((p_next == '0) && (m_next == '0)) state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      set_q           <= '0;
      way_q           <= '0;
      core_q          <= '0;
      excl_q          <= 1'b0;
      e_valid_q       <= 1'b0;
      e_owner_valid_q <= 1'b0;
      e_dirty_q       <= 1'b0;
      e_sharers_q     <= '0;
      e_owner_id_q    <= '0;
      p_q             <= '0;
      m_q             <= '0;
      d_q             <= 1'b0;
      ton_q           <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            set_q  <= req_set_i;
            way_q  <= req_way_i;
            core_q <= req_core_i;
            excl_q <= req_excl_i;
          end
        end
        LOOKUP: begin
          e_valid_q       <= sel_valid;
          e_owner_valid_q <= sel_owner_valid;
          e_dirty_q       <= sel_dirty;
          e_sharers_q     <= sel_sharers;
          e_owner_id_q    <= sel_owner_id;
          p_q             <= p_init;
          m_q             <= p_init;
          d_q             <= sel_valid & sel_dirty;
          ton_q           <= excl_q;
        end
        PROBE: begin
          p_q <= p_next;
          m_q <= m_next;
          d_q <= d_next;
        end
        default: ;
      endcase
    end
  end

  // Strobes are masked while rst_n is low so an abandoned request never writes or completes
  always_comb begin
    req_ready_o          = (state_q == IDLE);
    busy_o               = (state_q != IDLE);
    probe_valid_o        = 1'b0;
    probe_core_o         = '0;
    probe_toN_o          = 1'b0;
    dir_we_o             = 1'b0;
    done_o               = 1'b0;
    done_dirty_o         = 1'b0;
    dir_wr_set_o         = '0;
    dir_wr_way_o         = '0;
    dir_wr_valid_o       = 1'b0;
    dir_wr_sharers_o     = '0;
    dir_wr_owner_valid_o = 1'b0;
    dir_wr_owner_id_o    = '0;
    dir_wr_dirty_o       = 1'b0;
    if (state_q == PROBE && p_q != '0) begin
      probe_valid_o = rst_n;
      probe_core_o  = low_idx;
      probe_toN_o   = ton_q;
    end
    if (state_q == UPDATE) begin
      dir_we_o     = rst_n;
      done_o       = rst_n;
      done_dirty_o = d_q;
      dir_wr_set_o = set_q;
      dir_wr_way_o = way_q;
      if (excl_q) begin
        dir_wr_valid_o       = 1'b1;
        dir_wr_owner_valid_o = 1'b1;
        dir_wr_owner_id_o    = core_q;
      end else if (e_owner_valid_q && (e_owner_id_q == core_q)) begin
        dir_wr_valid_o       = e_valid_q;
        dir_wr_sharers_o     = e_sharers_q;
        dir_wr_owner_valid_o = e_owner_valid_q;
        dir_wr_owner_id_o    = e_owner_id_q;
        dir_wr_dirty_o       = e_dirty_q;
      end else begin
        dir_wr_valid_o   = 1'b1;
        dir_wr_sharers_o = rq | (e_valid_q ? (e_owner_valid_q ? e_oh : e_sharers_q) : '0);
      end
    end
  end

endmodule

// File: doc/rv64g_l2_probe_ctrl.md
Name: rv64g_l2_probe_ctrl

Overview:
- Per-request coherence controller between the L2 request arbiter and the L2 directory.
- Reads one directory set and selects the way named by the request.
- Computes which cores must be probed, then issues probes one at a time and counts acks.
- Writes the updated directory entry back through the directory write port and signals completion to the L2 pipeline.
- Handles one request at a time.

Parameters:
SETS, 256, number of directory sets
WAYS, 16, ways per set
CORES, 4, number of L1 clients; OID = $clog2(CORES)

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
req_valid_i  in  1  request valid
req_ready_o  out  1  controller idle and accepting
req_set_i  in  $clog2(SETS)  target set
req_way_i  in  $clog2(WAYS)  target way (hit or victim already chosen)
req_core_i  in  OID  requesting core
req_excl_i  in  1  1=acquire exclusive (toT), 0=acquire shared (toB)
dir_rd_set_o  out  $clog2(SETS)  directory read set (combinational read)
dir_rd_valid_i  in  WAYS  per-way valid
dir_rd_sharers_i  in  WAYS*CORES  per-way sharer masks
dir_rd_owner_valid_i  in  WAYS  per-way owner valid
dir_rd_owner_id_i  in  WAYS*OID  per-way owner id
dir_rd_dirty_i  in  WAYS  per-way dirty
dir_we_o  out  1  directory write strobe
dir_wr_set_o, dir_wr_way_o  out  set/way widths  write address
dir_wr_valid_o, dir_wr_sharers_o, dir_wr_owner_valid_o, dir_wr_owner_id_o, dir_wr_dirty_o  out  1/CORES/1/OID/1  new entry
probe_valid_o  out  1  probe request
probe_ready_i  in  1  probe accepted
probe_core_o  out  OID  probe target
probe_toN_o  out  1  1=invalidate, 0=downgrade to shared
ack_valid_i  in  1  probe ack
ack_core_i  in  OID  acking core
ack_dirty_i  in  1  ack carried dirty data
done_o  out  1  one-cycle completion pulse
done_dirty_o  out  1  L2 data must be marked dirty
busy_o  out  1  state != IDLE

Behaviour:
- States: IDLE, LOOKUP, PROBE, UPDATE.
- Reset: state=IDLE; every output 0 except req_ready_o=1; all capture registers cleared.
- Reset asserted mid-operation: abandon the request, issue no directory write, no done_o; any outstanding acks are ignored.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i: capture set, way, core, excl; go LOOKUP.
- LOOKUP (1 cycle):
  - dir_rd_set_o = captured set; dir_rd_set_o always shows the captured set.
  - Latch the selected way entry E, with rq = onehot(req_core) and oh = onehot(E.owner_id).
  - E.valid=0: probe mask P=0.
  - excl: P = (E.owner_valid ? oh : E.sharers) & ~rq; toN=1.
  - shared: P = (E.owner_valid && E.owner_id != req_core) ? oh : 0; toN=0.
  - Pending mask M = P; dirty accumulator D = E.valid & E.dirty.
  - Next state: PROBE if P != 0, else UPDATE.
- PROBE:
  - Issue phase: probe_valid_o=1 with probe_core_o = lowest set bit of P.
    - On probe_ready_i, clear that bit of P; the next probe is offered the following cycle.
    - probe_core_o and probe_toN_o stay stable while probe_valid_o=1 and probe_ready_i=0.
  - Ack phase: ack_valid_i with M[ack_core_i]=1 clears M[ack_core_i] and sets D |= ack_dirty_i.
    - Acks for cores not in M are ignored.
    - Acks may arrive before all probes are issued; an ack and a probe handshake may complete in the same cycle.
  - Exit: go UPDATE when P==0 and M==0, counting clears made in the current cycle.
- UPDATE (1 cycle):
  - dir_we_o=1 and done_o=1; dir_wr_set_o/dir_wr_way_o = captured set/way; done_dirty_o = D.
  - excl: valid=1, owner_valid=1, owner_id=req_core, sharers=0, dirty=0.
  - shared, E.owner_valid and owner==req_core: entry written unchanged (owner retained).
  - shared, otherwise: valid=1, owner_valid=0, dirty=0, sharers = rq | (E.valid ? (E.owner_valid ? oh : E.sharers) : 0).
  - Next state: IDLE.
- Latency: with zero probes, accept at cycle 0, done_o at cycle 2, req_ready_o high again at cycle 3.
- Written entries always satisfy both invariants: dirty implies owner_valid, and owner_valid implies sharers==0.

Test Plan:
- Invalid entry, excl from core 2 -> no probes; done at cycle 2; write valid=1, owner_valid=1, owner_id=2, sharers=0000, done_dirty=0.
- Sharers=1011, excl from core 0 -> probes to cores 1 then 3 with toN=1; after both acks, write owner=0, sharers=0000.
- Owner=3 dirty, shared from core 1 -> one probe to core 3 with toN=0; ack_dirty=1; write sharers=1010, owner_valid=0; done_dirty=1.
- probe_ready_i low for 3 cycles -> probe_core_o/probe_toN_o stable; ack for core 3 arriving in the same cycle as probe 1 is accepted; spurious ack from core 2 is ignored and does not end PROBE early.
- Sharers=0001, shared from core 0 -> no probe; write sharers=0001.
- rst_n asserted during PROBE -> no dir_we_o, no done_o; req_ready_o=1 the cycle after rst_n deasserts.
